// File: rtl/sdram_line_fetcher.sv
// sdram_line_fetcher: fetches a burst of 32-bit words from an SDRAM controller
// read port into a local line buffer that a consumer reads by index.
// Optional build macro: SDRAM_LINE_FETCHER_TIMEOUT_EN adds a watchdog on the
// WAIT state that aborts the fetch with a fetch_error pulse.
module sdram_line_fetcher #(
  parameter int LINE_WORDS     = 128,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fetch_start,
  input  logic [22:0]                   fetch_address,
  input  logic [8:0]                    fetch_words,
  output logic                          fetch_busy,
  output logic                          fetch_done,
  output logic                          fetch_error,
  output logic [8:0]                    fetch_count,
  output logic                          rd_request,
  output logic [22:0]                   rd_address,
  output logic [8:0]                    rd_burst_length,
  input  logic                          rd_available,
  input  logic [31:0]                   rd_data,
  input  logic [$clog2(LINE_WORDS)-1:0] buf_index,
  output logic [31:0]                   buf_data
);
  localparam int AW = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {IDLE, REQUEST, WAIT, RECEIVE, DONE} state_t;

  state_t      state, state_nxt;
  logic [22:0] addr_q;
  logic [8:0]  len_q;
  logic [8:0]  cnt;
  logic [8:0]  words_clamp;
  logic        wr_en;
  logic        timeout;
  logic [31:0] mem [LINE_WORDS];

  // Requests larger than the buffer are trimmed to the buffer depth.
  always_comb begin
    words_clamp = fetch_words;
    if (fetch_words > 9'(LINE_WORDS)) words_clamp = 9'(LINE_WORDS);
  end

  // Store a word only while the stream is still short of the latched count.
  assign wr_en = ((state == WAIT) || (state == RECEIVE)) && rd_available && (cnt < len_q);

`ifdef SDRAM_LINE_FETCHER_TIMEOUT_EN
  logic [12:0] tcnt;
  // Watchdog fires on the TIMEOUT_CYCLES-th cycle spent in WAIT with no strobe.
  assign timeout = (state == WAIT) && !rd_available && (tcnt == 13'(TIMEOUT_CYCLES - 1));

  // Watchdog counter, restarted each time a request is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tcnt <= '0;
    else if (state == REQUEST) tcnt <= '0;
    else if (state == WAIT)    tcnt <= tcnt + 13'd1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  assign fetch_busy      = (state != IDLE);
  assign fetch_done      = (state == DONE) || timeout;
  assign fetch_error     = timeout;
  assign rd_request      = (state == REQUEST);
  assign rd_address      = addr_q;
  assign rd_burst_length = len_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; fetch_start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_start) state_nxt = (words_clamp == 9'd0) ? DONE : REQUEST;
      REQUEST: state_nxt = WAIT;
      WAIT: begin
        if (rd_available) state_nxt = RECEIVE;
        else if (timeout) state_nxt = IDLE;
      end
      RECEIVE: if (!rd_available) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, word counter and result count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      len_q       <= '0;
      cnt         <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        IDLE: if (fetch_start) begin
          addr_q <= fetch_address;
          len_q  <= words_clamp;
          cnt    <= '0;
          if (words_clamp == 9'd0) fetch_count <= '0;
        end
        RECEIVE: if (!rd_available) fetch_count <= cnt;
        default: ;
      endcase
      if (wr_en)   cnt <= cnt + 9'd1;
      if (timeout) fetch_count <= '0;
    end
  end

  // Line buffer write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt[AW-1:0]] <= rd_data;
  end

  // Registered read port; a same-cycle write to the same index returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) buf_data <= '0;
    else        buf_data <= mem[buf_index];
  end
endmodule

// File: tb/tb_sdram_line_fetcher.sv
// Directed bench for sdram_line_fetcher (LINE_WORDS=128). Inputs change 1ns
// after each rising edge; outputs are sampled at that same point.
module tb_sdram_line_fetcher;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic [22:0] fetch_address = '0;
  logic [8:0]  fetch_words = '0;
  logic        fetch_busy, fetch_done, fetch_error;
  logic [8:0]  fetch_count;
  logic        rd_request;
  logic [22:0] rd_address;
  logic [8:0]  rd_burst_length;
  logic        rd_available = 1'b0;
  logic [31:0] rd_data = '0;
  logic [6:0]  buf_index = '0;
  logic [31:0] buf_data;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;
  int req_pulses = 0;

  sdram_line_fetcher #(.LINE_WORDS(128), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .fetch_address(fetch_address),
    .fetch_words(fetch_words), .fetch_busy(fetch_busy), .fetch_done(fetch_done),
    .fetch_error(fetch_error), .fetch_count(fetch_count), .rd_request(rd_request),
    .rd_address(rd_address), .rd_burst_length(rd_burst_length), .rd_available(rd_available),
    .rd_data(rd_data), .buf_index(buf_index), .buf_data(buf_data)
  );

  always #5 clk = ~clk;

  // Count rd_request cycles seen by the controller.
  always @(posedge clk) if (rd_request === 1'b1) req_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_buf(input int idx, input logic [31:0] exp, input string tag);
    buf_index = 7'(idx);
    tick();
    chk(tag, buf_data, exp);
  endtask

  initial begin
    // ---- reset state
    #2;
    chk("rst_busy", 32'(fetch_busy), 0);
    chk("rst_done", 32'(fetch_done), 0);
    chk("rst_err", 32'(fetch_error), 0);
    chk("rst_cnt", 32'(fetch_count), 0);
    chk("rst_req", 32'(rd_request), 0);
    chk("rst_addr", 32'(rd_address), 0);
    chk("rst_len", 32'(rd_burst_length), 0);
    chk("rst_bufdata", buf_data, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- basic 4-word fetch at 0x000400
    fetch_start = 1'b1; fetch_address = 23'h000400; fetch_words = 9'd4;
    tick();                                  // now REQUEST
    fetch_start = 1'b0; fetch_address = '0; fetch_words = '0;
    chk("t1_req", 32'(rd_request), 1);
    chk("t1_addr", 32'(rd_address), 32'h400);
    chk("t1_len", 32'(rd_burst_length), 4);
    chk("t1_busy", 32'(fetch_busy), 1);
    tick();                                  // now WAIT
    chk("t1_req_low", 32'(rd_request), 0);
    for (int i = 0; i < 4; i++) begin
      rd_available = 1'b1; rd_data = 32'hA000_0000 + 32'(i);
      tick();
    end
    rd_available = 1'b0; rd_data = '0;
    chk("t1_nodone_yet", 32'(fetch_done), 0);
    chk("t1_addr_hold", 32'(rd_address), 32'h400);
    tick();                                  // now DONE
    chk("t1_done", 32'(fetch_done), 1);
    chk("t1_count", 32'(fetch_count), 4);
    chk("t1_len_hold", 32'(rd_burst_length), 4);
    tick();                                  // back to IDLE
    chk("t1_done_pulse", 32'(fetch_done), 0);
    chk("t1_idle", 32'(fetch_busy), 0);
    chk("t1_pulses", 32'(req_pulses), 1);
    for (int i = 0; i < 4; i++) rd_buf(i, 32'hA000_0000 + 32'(i), "t1_buf");

    // ---- zero-word fetch
    fetch_start = 1'b1; fetch_words = 9'd0; fetch_address = 23'h000123;
    tick();                                  // straight to DONE
    fetch_start = 1'b0;
    chk("t3_done", 32'(fetch_done), 1);
    chk("t3_req", 32'(rd_request), 0);
    chk("t3_count", 32'(fetch_count), 0);
    tick();
    chk("t3_idle", 32'(fetch_busy), 0);
    chk("t3_pulses", 32'(req_pulses), 1);

    // ---- oversize fetch clamps to 128; start while busy is ignored
    fetch_start = 1'b1; fetch_words = 9'd300; fetch_address = 23'h001000;
    tick();                                  // REQUEST
    fetch_start = 1'b0; fetch_words = '0; fetch_address = '0;
    chk("t4_len", 32'(rd_burst_length), 128);
    tick();                                  // WAIT
    for (int i = 0; i < 128; i++) begin
      rd_available = 1'b1; rd_data = 32'hB000_0000 + 32'(i);
      fetch_start = (i == 3);
      fetch_words = 9'd5; fetch_address = 23'h000007;
      tick();
    end
    fetch_start = 1'b0; rd_available = 1'b0; rd_data = '0;
    tick();                                  // DONE
    chk("t4_done", 32'(fetch_done), 1);
    chk("t4_count", 32'(fetch_count), 128);
    chk("t4_addr", 32'(rd_address), 32'h1000);
    chk("t4_len_hold", 32'(rd_burst_length), 128);
    tick();
    chk("t4_idle", 32'(fetch_busy), 0);
    chk("t4_pulses", 32'(req_pulses), 2);
    rd_buf(0, 32'hB000_0000, "t4_buf0");
    rd_buf(127, 32'hB000_007F, "t4_buf127");

    // ---- 4-word fetch with a fifth, surplus strobe
    fetch_start = 1'b1; fetch_words = 9'd4; fetch_address = 23'h000020;
    tick();
    fetch_start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      rd_available = 1'b1; rd_data = 32'hC000_0000 + 32'(i);
      tick();
    end
    rd_available = 1'b0;
    tick();
    chk("t2_done", 32'(fetch_done), 1);
    chk("t2_count", 32'(fetch_count), 4);
    tick();
    rd_buf(3, 32'hC000_0003, "t2_buf3");
    rd_buf(4, 32'hB000_0004, "t2_buf4_kept");

    // ---- reset after 2 of 8 words
    fetch_start = 1'b1; fetch_words = 9'd8; fetch_address = 23'h000040;
    tick();
    fetch_start = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      rd_available = 1'b1; rd_data = 32'hD000_0000 + 32'(i);
      tick();
    end
    rd_data = 32'hD000_0002;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(fetch_busy), 0);
    chk("t5_addr", 32'(rd_address), 0);
    chk("t5_len", 32'(rd_burst_length), 0);
    chk("t5_count", 32'(fetch_count), 0);
    chk("t5_bufdata", buf_data, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 2; i < 8; i++) begin
      rd_available = 1'b1; rd_data = 32'hD000_0000 + 32'(i);
      tick();
    end
    rd_available = 1'b0;
    chk("t5_stay_idle", 32'(fetch_busy), 0);
    chk("t5_nodone", 32'(fetch_done), 0);
    chk("t5_pulses", 32'(req_pulses), 4);
    rd_buf(0, 32'hD000_0000, "t5_buf0");
    rd_buf(1, 32'hD000_0001, "t5_buf1");
    rd_buf(2, 32'hC000_0002, "t5_buf2_kept");

`ifdef SDRAM_LINE_FETCHER_TIMEOUT_EN
    // ---- watchdog: controller never strobes
    begin
      int n = 0;
      fetch_start = 1'b1; fetch_words = 9'd2; fetch_address = 23'h000080;
      tick();                                // REQUEST
      fetch_start = 1'b0;
      while (n < 5000 && fetch_error !== 1'b1) begin
        tick();
        n++;
      end
      chk("to_cycles", 32'(n), 4096);
      chk("to_done", 32'(fetch_done), 1);
      tick();
      chk("to_idle", 32'(fetch_busy), 0);
      chk("to_count", 32'(fetch_count), 0);
      chk("to_err_pulse", 32'(fetch_error), 0);
    end
`else
    chk("noto_err", 32'(fetch_error), 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
